// File: rtl/filter_addr_gen.sv
// Tap read address generator for an FIR-style filter pass over a sample file.
// Define FILTER_ADDR_SKIP_EN to drop boundary taps (k > n) instead of clamping them to sample 0.
module filter_addr_gen #(
    parameter int unsigned NTAPS       = 8,
    parameter int unsigned STRIDE_LOG2 = 2,
    parameter logic [31:0] SENTINEL    = 32'd100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] count,
    input  logic        count_done,
    input  logic        addr_ready,
    output logic        cnt_en,
    output logic        pause,
    output logic [31:0] addr,
    output logic        addr_valid,
    output logic [3:0]  tap_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FINISH} state_e;

    localparam logic [3:0] LAST_K = 4'(NTAPS - 1);

    state_e      state_q;
    logic [31:0] base_q;
    logic [31:0] n_q;
    logic [3:0]  k_q;
    logic        seen_q;
    logic        cnt_en_q;
    logic [31:0] addr_q;
    logic        addr_valid_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  k_inc;
    logic        issue_exit;

    // Sample index n-k, clamped to 0 for boundary taps, scaled to bytes; wraps modulo 2^32.
    function automatic logic [31:0] tap_addr(input logic [31:0] b,
                                             input logic [31:0] n,
                                             input logic [4:0]  k);
        logic [31:0] idx;
        idx = ({27'd0, k} > n) ? 32'd0 : n - {27'd0, k};
        return b + (idx << STRIDE_LOG2);
    endfunction

    assign k_inc = {1'b0, k_q} + 5'd1;

`ifdef FILTER_ADDR_SKIP_EN
    logic next_is_boundary;
    assign next_is_boundary = {27'd0, k_inc} > n_q;
    assign issue_exit       = (k_q == LAST_K) || next_is_boundary;
`else
    assign issue_exit       = (k_q == LAST_K);
`endif

    // NOTE: every state register is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            n_q          <= '0;
            k_q          <= '0;
            seen_q       <= 1'b0;
            cnt_en_q     <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        seen_q   <= 1'b0;
                        cnt_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    if (count_done) begin
                        if (seen_q) begin
                            cnt_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end
                    end else if (count != SENTINEL) begin
                        n_q          <= count;
                        seen_q       <= 1'b1;
                        k_q          <= '0;
                        addr_q       <= tap_addr(base_q, count, 5'd0);
                        addr_valid_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // count_done is deliberately not looked at here; the sample finishes first.
                    if (addr_ready) begin
                        if (issue_exit) begin
                            addr_valid_q <= 1'b0;
                            state_q      <= FETCH;
                        end else begin
                            k_q    <= k_inc[3:0];
                            addr_q <= tap_addr(base_q, n_q, k_inc);
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The upstream counter may only advance while a sample is being fetched.
    assign pause      = (state_q != FETCH);
    assign cnt_en     = cnt_en_q;
    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign tap_idx    = k_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_filter_addr_gen.sv
// Self-checking bench for filter_addr_gen: bench-side upstream counter model plus an address scoreboard.
// Expectations follow FILTER_ADDR_SKIP_EN the same way the design does.
module tb_filter_addr_gen;

    localparam int unsigned NT   = 4;
    localparam int unsigned SL   = 2;
    localparam logic [31:0] SENT = 32'd100000000;
`ifdef FILTER_ADDR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  tap;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        addr_ready;
    logic        cnt_en;
    logic        pause;
    logic [31:0] addr;
    logic        addr_valid;
    logic [3:0]  tap_idx;
    logic        busy;
    logic        done;

    logic [31:0] cnt_m;
    logic        cdone_m;
    logic [31:0] fsize_m;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   gap_pending = 1'b0;

    filter_addr_gen #(.NTAPS(NT), .STRIDE_LOG2(SL), .SENTINEL(SENT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .count      (cnt_m),
        .count_done (cdone_m),
        .addr_ready (addr_ready),
        .cnt_en     (cnt_en),
        .pause      (pause),
        .addr       (addr),
        .addr_valid (addr_valid),
        .tap_idx    (tap_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Upstream filesize counter: idles at SENT, steps 0..fsize_m while enabled and not paused, then flags done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m   <= SENT;
            cdone_m <= 1'b0;
        end else if (!cnt_en) begin
            cnt_m   <= SENT;
            cdone_m <= 1'b0;
        end else if (!pause && !cdone_m) begin
            if (cnt_m == SENT) begin
                cnt_m <= 32'd0;
            end else if (cnt_m == fsize_m) begin
                cdone_m <= 1'b1;
                cnt_m   <= SENT;
            end else begin
                cnt_m <= cnt_m + 32'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference sequence: tap k of sample n reads sample max(n-k,0); boundary taps dropped when skipping.
    task automatic push_expected(input logic [31:0] b, input int fsize);
        exp_t        e;
        logic [31:0] idx;
        for (int n = 0; n <= fsize; n++) begin
            for (int k = 0; k < int'(NT); k++) begin
                if (!(SKIP && k > n)) begin
                    idx    = (k > n) ? 32'd0 : 32'(n - k);
                    e.addr = b + (idx << SL);
                    e.tap  = 4'(k);
                    e.last = (k == int'(NT) - 1) || (SKIP && k == n);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Scoreboard monitor: pops one expected tap per handshake, and checks the bubble after a sample's last tap.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gap_pending) begin
                check("gap_after_last", 32'(addr_valid), 32'd0);
                gap_pending = 1'b0;
            end
            if (rst_n && addr_valid && addr_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_tap", addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", addr, e.addr);
                    check("tap_idx", 32'(tap_idx), 32'(e.tap));
                    if (e.last) gap_pending = 1'b1;
                end
            end
        end
    end

    task automatic start_pass(input logic [31:0] b, input int fsize);
        push_expected(b, fsize);
        fsize_m   = 32'(fsize);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = $urandom;
    endtask

    // mode 0: always ready; 1: random backpressure; 2: 5-cycle stall on tap 2 of sample 3, then a start pulse while busy.
    task automatic run_until_done(input int mode, input logic [31:0] b);
        int          cyc;
        bit          got;
        bit          stalled;
        logic [31:0] s_addr;
        logic [31:0] s_cnt;
        logic [3:0]  s_tap;
        cyc = 0; got = 1'b0; stalled = 1'b0;
        while (!got && cyc < 3000) begin
            addr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2 && !stalled && addr_valid && tap_idx == 4'd2 && addr == b + 32'd4) begin
                addr_ready = 1'b0;
                s_addr = addr; s_tap = tap_idx; s_cnt = cnt_m;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_addr", addr, s_addr);
                    check("stall_tap", 32'(tap_idx), 32'(s_tap));
                    check("stall_valid", 32'(addr_valid), 32'd1);
                    check("stall_pause", 32'(pause), 32'd1);
                    check("stall_count", cnt_m, s_cnt);
                    @(posedge clk); #1;
                end
                addr_ready = 1'b1;
                start      = 1'b1;
                base_addr  = 32'hDEAD_0000;
                stalled    = 1'b1;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("done_cnt_en", 32'(cnt_en), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
                check("done_drained", 32'(exp_q.size()), 32'd0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (mode == 2) check("stall_hit", 32'(stalled), 32'd1);
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_width", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        bit seen_valid;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; addr_ready = 1'b0; fsize_m = '0;
        #3;
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_pause", 32'(pause), 32'd1);
        check("rst_addr", addr, 32'd0);
        check("rst_tap_idx", 32'(tap_idx), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Small file, full-rate sink.
        start_pass(32'h0000_1000, 2);
        run_until_done(0, 32'h0000_1000);

        // Longer file with a held-off sink and an ignored start pulse mid-pass.
        start_pass(32'h0000_2000, 5);
        run_until_done(2, 32'h0000_2000);

        // Single-sample file: every tap past k=0 is a boundary tap.
        start_pass(32'h8000_0000, 0);
        run_until_done(1, 32'h8000_0000);

        // Abort mid-issue with reset; nothing may happen until the next start.
        start_pass(32'h0000_3000, 4);
        addr_ready = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 50 && !seen_valid; i++) begin
            @(posedge clk); #1;
            seen_valid = addr_valid;
        end
        check("pre_reset_valid", 32'(seen_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(addr_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pause", 32'(pause), 32'd1);
        check("abort_cnt_en", 32'(cnt_en), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end
        check("post_rst_cnt_en", 32'(cnt_en), 32'd0);
        check("post_rst_valid", 32'(addr_valid), 32'd0);

        // Resume with a base that wraps past 2^32 at sample 3 tap 0 (0xFFFFFFF8 + 12 -> 0x4).
        start_pass(32'hFFFF_FFF8, 3);
        run_until_done(1, 32'hFFFF_FFF8);

        repeat (3) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_addr_gen.md
FILTER_ADDR_GEN -- requirements
Module: filter_addr_gen

Interface
REQ-001 Parameter NTAPS, default 8: filter taps issued per sample; range 1..16.
REQ-002 Parameter STRIDE_LOG2, default 2: byte stride per sample is 2^STRIDE_LOG2.
REQ-003 Parameter SENTINEL, default 100000000: idle count value from the upstream counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a file pass; ignored unless in IDLE.
REQ-007 base_addr  input  32  byte address of sample 0; sampled on start.
REQ-008 count  input  32  sample index from the upstream filesize counter.
REQ-009 count_done  input  1  upstream counter done flag.
REQ-010 addr_ready  input  1  downstream memory accepts addr this cycle.
REQ-011 cnt_en  output  1  enable to the upstream counter.
REQ-012 pause  output  1  hold request to the upstream counter.
REQ-013 addr  output  32  tap read byte address.
REQ-014 addr_valid  output  1  addr is valid.
REQ-015 tap_idx  output  4  tap number k of the current addr.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when the pass completes.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, ISSUE and FINISH; all outputs are registered except pause, which is decoded from state.
REQ-019 In IDLE, when start=1 the block SHALL latch base_addr, clear the seen flag, set cnt_en=1 and move to FETCH.
REQ-020 pause SHALL be 0 only in FETCH and SHALL be 1 in every other state.
REQ-021 In FETCH, if count_done=0 and count!=SENTINEL, the block SHALL capture n=count, set seen=1, set k=0 and move to ISSUE.
REQ-022 In FETCH, if count_done=1 and seen=1, the block SHALL move to FINISH; otherwise it SHALL stay in FETCH.
REQ-023 In ISSUE, addr SHALL equal base + ((n-k) << STRIDE_LOG2), computed modulo 2^32 with wrap and no saturation.
REQ-024 addr, tap_idx and addr_valid SHALL hold stable while addr_valid=1 and addr_ready=0.
REQ-025 A tap SHALL retire on a cycle with addr_valid=1 and addr_ready=1; k then increments and the next tap is presented on the following cycle.
REQ-026 When tap k=NTAPS-1 retires, the FSM SHALL go to FETCH and addr_valid SHALL be 0 on the following cycle.
REQ-027 Taps with k>n are boundary taps; their handling is set by REQ-035 and REQ-036.
REQ-028 In FINISH, the block SHALL drive cnt_en=0 and done=1 for one cycle, then return to IDLE.
REQ-029 start SHALL be ignored in every state except IDLE, and SHALL NOT restart a pass in progress.
REQ-030 count_done asserting while in ISSUE SHALL be acted on only at the next FETCH, so the current sample always completes all its taps.

Reset
REQ-031 When rst_n=0, state SHALL be IDLE and cnt_en, addr_valid, busy, done, addr, tap_idx, n, k and seen SHALL be 0, with pause=1.
REQ-032 Reset asserted mid-pass SHALL abort immediately and asynchronously drop addr_valid, with no done pulse.
REQ-033 After rst_n deasserts, the block SHALL take no action until the next start.

Configuration
REQ-034 The macro FILTER_ADDR_SKIP_EN SHALL select boundary-tap handling.
REQ-035 With FILTER_ADDR_SKIP_EN defined, taps with k>n SHALL NOT be presented; when the next tap is a boundary tap, the FSM SHALL go to FETCH instead.
REQ-036 Without FILTER_ADDR_SKIP_EN, taps with k>n SHALL be presented with addr=base (index clamped to 0), so every sample issues exactly NTAPS taps.

Verification
REQ-037 NTAPS=4, base=0x1000, counter filesize=2, addr_ready=1, with skip -> addr sequence 0x1000; 0x1004,0x1000; 0x1008,0x1004,0x1000; then done pulse and cnt_en=0.
REQ-038 The same stimulus without skip -> 12 addresses; sample 0 issues 0x1000 four times, and sample 1 issues 0x1004, then 0x1000 three times.
REQ-039 addr_ready held low 5 cycles on tap 2 of sample 3 -> addr, tap_idx and addr_valid are stable for all 5 cycles, pause stays 1 and count is unchanged.
REQ-040 base=0xFFFFFFF8, n=3, k=0 -> addr=0x00000004 (wrap).
REQ-041 rst_n pulsed low in ISSUE -> addr_valid=0 in the same cycle, state is IDLE, no done, and start is required to resume.
REQ-042 start pulsed while busy=1 -> no effect and the address sequence is unchanged.
